// File: rtl/dm_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM states, port ids and
// byte-enable constants.
package dm_arb_defs;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER   = 2'd1,
        RMW_RD = 2'd2,
        RMW_WR = 2'd3
    } state_t;

    typedef logic port_id_t;

    localparam port_id_t   PORT_A  = 1'b0;
    localparam port_id_t   PORT_B  = 1'b1;
    localparam logic [3:0] BE_FULL = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

    // A write touching some but not all lanes must read the old word first.
    function automatic logic needs_rmw(input logic we, input logic [3:0] be);
        return we && (be != BE_FULL) && (be != BE_NONE);
    endfunction

endpackage

// File: rtl/dm_port_arbiter_rr_picker.sv
// Combinational winner selection between ports A and B: round-robin on the
// last served port, or fixed priority to A.
module dm_rr_picker
    import dm_arb_defs::*;
(
    input  logic     req_a,
    input  logic     req_b,
    input  port_id_t last,
    input  logic     prio_mode,
    output port_id_t gnt_id,
    output logic     gnt_vld
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        gnt_vld = req_a || req_b;
        gnt_id  = PORT_A;
        if (req_b && (!req_a || (!prio_mode && last == PORT_A))) begin
            gnt_id = PORT_B;
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-port front end for the single-port word-wide data memory: arbitrates per
// transaction and turns partial-lane stores into read-modify-write.
module dm_port_arbiter
    import dm_arb_defs::*;
#(
    parameter int ADDR_W    = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              clr_n,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [3:0]        a_be,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [31:0]       a_wd,
    output logic              a_gnt,
    output logic              a_done,
    output logic [31:0]       a_rd,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [3:0]        b_be,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       b_wd,
    output logic              b_gnt,
    output logic              b_done,
    output logic [31:0]       b_rd,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_dr,

    output logic              busy
);

    localparam logic              PRIO_FIXED = (PRIO_MODE != 0);
    localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);

    state_t      state;
    port_id_t    last_served;
    port_id_t    cmd_id;
    logic        cmd_we;
    logic [3:0]  cmd_be;
    logic [31:0] cmd_wd;

    port_id_t          pick_id;
    logic              pick_vld;
    logic              grant;
    logic              sel_we;
    logic [3:0]        sel_be;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wd;
    logic [31:0]       merged;

    dm_rr_picker u_picker (
        .req_a     (a_req),
        .req_b     (b_req),
        .last      (last_served),
        .prio_mode (PRIO_FIXED),
        .gnt_id    (pick_id),
        .gnt_vld   (pick_vld)
    );

    // Grants are only offered from IDLE and are forced low while reset is held.
    assign grant = clr_n && (state == IDLE) && pick_vld;
    assign a_gnt = grant && (pick_id == PORT_A);
    assign b_gnt = grant && (pick_id == PORT_B);
    assign busy  = (state != IDLE);

    always_comb begin
        sel_we   = a_we;
        sel_be   = a_be;
        sel_addr = a_addr;
        sel_wd   = a_wd;
        if (pick_id == PORT_B) begin
            sel_we   = b_we;
            sel_be   = b_be;
            sel_addr = b_addr;
            sel_wd   = b_wd;
        end
    end

    always_comb begin
        merged = mem_dr;
        for (int i = 0; i < 4; i++) begin
            if (cmd_be[i]) merged[8*i +: 8] = cmd_wd[8*i +: 8];
        end
    end

    // NOTE: state and outputs use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            // NOTE: the command/data registers are reset too; they are few and
            // this keeps outputs deterministic after a mid-transaction reset.
            state       <= IDLE;
            last_served <= PORT_B;
            cmd_id      <= PORT_A;
            cmd_we      <= 1'b0;
            cmd_be      <= BE_NONE;
            cmd_wd      <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wd      <= '0;
            a_done      <= 1'b0;
            b_done      <= 1'b0;
            a_rd        <= '0;
            b_rd        <= '0;
        end else begin
            a_done <= 1'b0;
            b_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        cmd_id      <= pick_id;
                        cmd_we      <= sel_we;
                        cmd_be      <= sel_be;
                        cmd_wd      <= sel_wd;
                        last_served <= pick_id;
                        mem_addr    <= sel_addr & WORD_MASK;
                        if (sel_we && sel_be == BE_FULL) begin
                            mem_we <= 1'b1;
                            mem_wd <= sel_wd;
                        end
                        state <= needs_rmw(sel_we, sel_be) ? RMW_RD : XFER;
                    end
                end
                XFER: begin
                    if (!cmd_we) begin
                        if (cmd_id == PORT_B) b_rd <= mem_dr;
                        else                  a_rd <= mem_dr;
                    end
                    mem_we <= 1'b0;
                    if (cmd_id == PORT_B) b_done <= 1'b1;
                    else                  a_done <= 1'b1;
                    state <= IDLE;
                end
                RMW_RD: begin
                    mem_wd <= merged;
                    mem_we <= 1'b1;
                    state  <= RMW_WR;
                end
                RMW_WR: begin
                    mem_we <= 1'b0;
                    if (cmd_id == PORT_B) b_done <= 1'b1;
                    else                  a_done <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Randomized scoreboard bench for dm_port_arbiter: a transaction-level model
// predicts grants, completions, read data and memory writes.
module tb_dm_port_arbiter;

    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [3:0]  a_be = 0, b_be = 0;
    logic [31:0] a_addr = 0, a_wd = 0, b_addr = 0, b_wd = 0;
    logic        a_gnt, a_done, b_gnt, b_done, mem_we, busy;
    logic [31:0] a_rd, b_rd, mem_addr, mem_wd, mem_dr;

    logic        p_a_req = 0, p_b_req = 0;
    logic        p_a_gnt, p_a_done, p_b_gnt, p_b_done, p_mem_we, p_busy;
    logic [31:0] p_a_rd, p_b_rd, p_mem_addr, p_mem_wd;
    logic [31:0] p_zero = '0;
    logic [3:0]  p_be0 = '0;

    logic [31:0] dm [64];
    assign mem_dr = dm[mem_addr[7:2]];

    dm_port_arbiter #(.ADDR_W(ADDR_W), .PRIO_MODE(0)) u_dut (
        .clk(clk), .clr_n(clr_n),
        .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wd(a_wd),
        .a_gnt(a_gnt), .a_done(a_done), .a_rd(a_rd),
        .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wd(b_wd),
        .b_gnt(b_gnt), .b_done(b_done), .b_rd(b_rd),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_dr(mem_dr),
        .busy(busy)
    );

    dm_port_arbiter #(.ADDR_W(ADDR_W), .PRIO_MODE(1)) u_dut_p1 (
        .clk(clk), .clr_n(clr_n),
        .a_req(p_a_req), .a_we(1'b0), .a_be(p_be0), .a_addr(p_zero), .a_wd(p_zero),
        .a_gnt(p_a_gnt), .a_done(p_a_done), .a_rd(p_a_rd),
        .b_req(p_b_req), .b_we(1'b0), .b_be(p_be0), .b_addr(p_zero), .b_wd(p_zero),
        .b_gnt(p_b_gnt), .b_done(p_b_done), .b_rd(p_b_rd),
        .mem_we(p_mem_we), .mem_addr(p_mem_addr), .mem_wd(p_mem_wd), .mem_dr(p_zero),
        .busy(p_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        case (i)
            4:       return 32'hCAFEBABE;
            8:       return 32'h11223344;
            default: return 32'h5A00_0000 ^ (32'(i) * 32'h0103_0507);
        endcase
    endfunction

    // Behavioural data memory: combinational read, write on rising edge.
    initial begin
        for (int i = 0; i < 64; i++) dm[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_we) dm[mem_addr[7:2]] <= mem_wd;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        bit          port;
        logic [31:0] rd;
        int          grant_cyc;
        int          done_cyc;
    } done_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          at_cyc;
    } wr_t;

    done_t       done_q[$];
    wr_t         wr_q[$];
    logic [31:0] ref_mem [64];
    logic [31:0] a_rd_exp, b_rd_exp;
    bit          last_b;
    bit          model_on = 0;

    task automatic model_grant(input bit wb);
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr, wd, m;
        int          word, lat;
        done_t       d;
        we   = wb ? b_we   : a_we;
        be   = wb ? b_be   : a_be;
        addr = (wb ? b_addr : a_addr) & ~32'd3;
        wd   = wb ? b_wd   : a_wd;
        word = int'(addr[7:2]);
        lat  = 2;
        if (!we) begin
            if (wb) b_rd_exp = ref_mem[word];
            else    a_rd_exp = ref_mem[word];
        end else if (be == 4'hF) begin
            ref_mem[word] = wd;
            wr_q.push_back('{addr, wd, cyc + 1});
        end else if (be != 4'h0) begin
            m = ref_mem[word];
            for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = wd[8*i +: 8];
            ref_mem[word] = m;
            wr_q.push_back('{addr, m, cyc + 2});
            lat = 3;
        end
        last_b      = wb;
        d.port      = wb;
        d.rd        = wb ? b_rd_exp : a_rd_exp;
        d.grant_cyc = cyc;
        d.done_cyc  = cyc + lat;
        done_q.push_back(d);
    endtask

    initial begin : monitor
        done_t d;
        wr_t   w;
        bit    wb, busy_exp;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (!clr_n) begin
                last_b   = 1'b1;
                a_rd_exp = '0;
                b_rd_exp = '0;
                done_q.delete();
                wr_q.delete();
            end else begin
                if (a_done || b_done) begin
                    check("done_one_port", {a_done, b_done} == 2'b11, 0);
                    if (done_q.size() == 0) begin
                        check("done_unexpected", {a_done, b_done}, 0);
                    end else begin
                        d = done_q.pop_front();
                        check("done_port", b_done, d.port);
                        check("done_cycle", cyc, d.done_cyc);
                        check(d.port ? "b_rd" : "a_rd", d.port ? b_rd : a_rd, d.rd);
                    end
                end
                if (mem_we) begin
                    if (wr_q.size() == 0) begin
                        check("mem_we_unexpected", mem_we, 0);
                    end else begin
                        w = wr_q.pop_front();
                        check("mem_addr", mem_addr, w.addr);
                        check("mem_wd", mem_wd, w.data);
                        check("mem_we_cycle", cyc, w.at_cyc);
                    end
                end
                if (model_on) begin
                    busy_exp = done_q.size() > 0 && cyc > done_q[0].grant_cyc
                               && cyc < done_q[0].done_cyc;
                    check("busy", busy, busy_exp);
                    if (done_q.size() == 0 && (a_req || b_req)) begin
                        wb = (a_req && b_req) ? !last_b : b_req;
                        check("grant", {a_gnt, b_gnt}, wb ? 2'b01 : 2'b10);
                        model_grant(wb);
                    end else begin
                        check("no_grant", {a_gnt, b_gnt}, 2'b00);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic rand_cmd(output logic we, output logic [3:0] be,
                            output logic [31:0] addr, output logic [31:0] wd);
        int r;
        we = 1'($urandom_range(0, 1));
        r  = $urandom_range(0, 3);
        be = (r == 0) ? 4'hF : (r == 1) ? 4'h0 : 4'($urandom_range(1, 14));
        addr = 32'($urandom_range(0, 63));
        wd   = $urandom;
    endtask

    task automatic drive_a(input int n);
        int w, k;
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                a_we = 0; a_be = 4'h0; a_addr = 32'h10; a_wd = 0;
            end else begin
                rand_cmd(a_we, a_be, a_addr, a_wd);
            end
            a_req = 1;
            w = 0;
            @(negedge clk);
            while (!a_gnt && w < 100) begin @(negedge clk); w++; end
            if (!a_gnt) begin check("a_gnt_timeout", 0, 1); a_req = 0; return; end
            @(posedge clk); #1 a_req = 0;
            w = 0;
            do begin @(posedge clk); #1; w++; end while (!a_done && w < 10);
            if (!a_done) begin check("a_done_timeout", 0, 1); return; end
            k = $urandom_range(0, 2);
            if (k > 0) begin repeat (k) @(posedge clk); #1; end
        end
    endtask

    task automatic drive_b(input int n);
        int w, k;
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                b_we = 1; b_be = 4'b0100; b_addr = 32'h20; b_wd = 32'h00AB0000;
            end else begin
                rand_cmd(b_we, b_be, b_addr, b_wd);
            end
            b_req = 1;
            w = 0;
            @(negedge clk);
            while (!b_gnt && w < 100) begin @(negedge clk); w++; end
            if (!b_gnt) begin check("b_gnt_timeout", 0, 1); b_req = 0; return; end
            @(posedge clk); #1 b_req = 0;
            w = 0;
            do begin @(posedge clk); #1; w++; end while (!b_done && w < 10);
            if (!b_done) begin check("b_done_timeout", 0, 1); return; end
            k = $urandom_range(0, 2);
            if (k > 0) begin repeat (k) @(posedge clk); #1; end
        end
    endtask

    initial begin : watchdog
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int w;
        clr_n = 0;
        #12;
        check("rst_ctrl", {a_gnt, b_gnt, a_done, b_done, mem_we, busy}, 6'b0);
        check("rst_rd", {a_rd, b_rd}, 64'b0);
        check("rst_mem", {mem_addr, mem_wd}, 64'b0);
        @(posedge clk); #3 clr_n = 1;
        @(posedge clk); #1;

        // Reset asserted while a partial store sits in RMW_RD.
        b_we = 1; b_be = 4'b0100; b_addr = 32'h20; b_wd = 32'h00AB0000; b_req = 1;
        w = 0;
        @(negedge clk);
        while (!b_gnt && w < 10) begin @(negedge clk); w++; end
        check("rmw_gnt", b_gnt, 1);
        @(posedge clk); #1 b_req = 0;
        check("rmw_busy", busy, 1);
        #2 clr_n = 0;
        #1;
        check("rmw_rst_ctrl", {a_gnt, b_gnt, a_done, b_done, mem_we, busy}, 6'b0);
        check("rmw_rst_mem", {mem_addr, mem_wd}, 64'b0);
        repeat (2) @(posedge clk);
        #3 clr_n = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rmw_rst_no_write", dm[8], 32'h11223344);
        model_on = 1;

        fork
            drive_a(40);
            drive_b(40);
        join
        repeat (5) @(posedge clk);
        #1;
        check("done_q_drained", done_q.size(), 0);
        check("wr_q_drained", wr_q.size(), 0);
        for (int i = 0; i < 64; i++) check($sformatf("dm[%0d]", i), dm[i], ref_mem[i]);

        // Fixed-priority instance: A keeps re-requesting on its done, B waits.
        p_a_req = 1; p_b_req = 1;
        for (int k = 0; k < 3; k++) begin
            w = 0;
            @(negedge clk);
            while (!p_a_gnt && w < 20) begin @(negedge clk); w++; end
            check("p1_a_first", {p_a_gnt, p_b_gnt}, 2'b10);
            @(posedge clk); #1 p_a_req = 0;
            w = 0;
            do begin @(posedge clk); #1; w++; end while (!p_a_done && w < 10);
            check("p1_a_done", p_a_done, 1);
            if (k < 2) p_a_req = 1;
        end
        @(negedge clk);
        check("p1_b_last", {p_a_gnt, p_b_gnt}, 2'b01);
        @(posedge clk); #1 p_b_req = 0;
        w = 0;
        do begin @(posedge clk); #1; w++; end while (!p_b_done && w < 10);
        check("p1_b_done", p_b_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
